toggle_activity_counter: RTL and testbench

// Switching-activity monitor sitting directly downstream of the gate-level DUT (e.g. full_adder nets a,b,c,sum,carry).

---
 rtl/toggle_activity_counter.sv | 134 +++++++++++++
 tb/tb_toggle_activity_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_activity_counter.sv
// Windowed 0->1 / 1->0 toggle counter for N_SIG nets with a valid/ready result port.
// Define ACT_SAT_EN to saturate counters at all-ones instead of wrapping.
module toggle_activity_counter #(
    parameter int N_SIG  = 5,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 64,
    localparam int TOT_W = CNT_W + $clog2(N_SIG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clear,
    input  logic [N_SIG-1:0]         sig_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     busy,
    output logic [N_SIG*CNT_W-1:0]   cnt_flat,
    output logic [TOT_W-1:0]         total,
    output logic                     overflow
);

    localparam int PC_W  = $clog2(N_SIG + 1);
    localparam int CYC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {IDLE, ARM, COUNT, HOLD} state_t;

    state_t             state, nxt;
    logic [N_SIG-1:0]   prev;
    logic [N_SIG-1:0]   tog;
    logic [CYC_W-1:0]   cyc;
    logic [CNT_W-1:0]   cnt [N_SIG];
    logic [PC_W-1:0]    pc;
    logic [TOT_W:0]     tot_sum;
    logic               last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (clear) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) nxt = ARM;
                ARM:     nxt = COUNT;
                COUNT:   if (last) nxt = HOLD;
                HOLD:    if (out_ready) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    always_comb begin
        tog = sig_in ^ prev;
        pc  = '0;
        for (int unsigned i = 0; i < N_SIG; i++) pc += PC_W'(tog[i]);
        // carry bit of tot_sum flags that the total would pass its limit
        tot_sum = {1'b0, total} + (TOT_W+1)'(pc);
        last    = (cyc == CYC_W'(WINDOW - 1));
    end

    always_comb begin
        cnt_flat = '0;
        for (int unsigned i = 0; i < N_SIG; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            cyc      <= '0;
            total    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < N_SIG; i++) cnt[i] <= '0;
        end else if (clear) begin
            prev     <= '0;
            cyc      <= '0;
            total    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < N_SIG; i++) cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        total    <= '0;
                        overflow <= 1'b0;
                        for (int unsigned i = 0; i < N_SIG; i++) cnt[i] <= '0;
                    end
                end
                ARM: begin
                    prev <= sig_in;
                    cyc  <= '0;
                end
                COUNT: begin
                    prev <= sig_in;
                    cyc  <= cyc + CYC_W'(1);
                    for (int unsigned i = 0; i < N_SIG; i++) begin
                        if (tog[i]) begin
                            if (cnt[i] == '1) begin
                                overflow <= 1'b1;
`ifdef ACT_SAT_EN
                                cnt[i] <= '1;
`else
                                cnt[i] <= '0;
`endif
                            end else begin
                                cnt[i] <= cnt[i] + CNT_W'(1);
                            end
                        end
                    end
                    if (tot_sum[TOT_W]) begin
                        overflow <= 1'b1;
`ifdef ACT_SAT_EN
                        total <= '1;
`else
                        total <= tot_sum[TOT_W-1:0];
`endif
                    end else begin
                        total <= tot_sum[TOT_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Scoreboard bench for toggle_activity_counter: three instances with different
// WINDOW/CNT_W settings, directed stimulus, monitors pop expected results on handshake.
module tb_toggle_activity_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_a, clear_a, rdy_a, vld_a, busy_a, ovf_a;
    logic [4:0]  sig_a;
    logic [79:0] cnt_a;
    logic [18:0] tot_a;

    logic        start_b, clear_b, rdy_b, vld_b, busy_b, ovf_b;
    logic [4:0]  sig_b;
    logic [79:0] cnt_b;
    logic [18:0] tot_b;

    logic        start_c, clear_c, rdy_c, vld_c, busy_c, ovf_c;
    logic [4:0]  sig_c;
    logic [14:0] cnt_c;
    logic [5:0]  tot_c;

    toggle_activity_counter #(.N_SIG(5), .CNT_W(16), .WINDOW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a), .sig_in(sig_a),
        .out_ready(rdy_a), .out_valid(vld_a), .busy(busy_a), .cnt_flat(cnt_a),
        .total(tot_a), .overflow(ovf_a));

    toggle_activity_counter #(.N_SIG(5), .CNT_W(16), .WINDOW(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear_b), .sig_in(sig_b),
        .out_ready(rdy_b), .out_valid(vld_b), .busy(busy_b), .cnt_flat(cnt_b),
        .total(tot_b), .overflow(ovf_b));

    toggle_activity_counter #(.N_SIG(5), .CNT_W(3), .WINDOW(12)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .clear(clear_c), .sig_in(sig_c),
        .out_ready(rdy_c), .out_valid(vld_c), .busy(busy_c), .cnt_flat(cnt_c),
        .total(tot_c), .overflow(ovf_c));

    typedef struct {
        logic [79:0] cnt;
        logic [18:0] tot;
        logic        ovf;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int tests  = 0;
    int failed = 0;

    task automatic chk(input string n, input logic [79:0] act, input logic [79:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h", n, act, req);
        end
    endtask

    task automatic unexpected(input string n);
        tests++;
        failed++;
        $display("FAIL %s: actual=out_valid with empty scoreboard required=no output", n);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (vld_a && rdy_a) begin
            if (qa.size() == 0) unexpected("a_out");
            else begin
                e = qa.pop_front();
                chk("a_cnt_flat", cnt_a, e.cnt);
                chk("a_total", 80'(tot_a), 80'(e.tot));
                chk("a_overflow", 80'(ovf_a), 80'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (vld_b && rdy_b) begin
            if (qb.size() == 0) unexpected("b_out");
            else begin
                e = qb.pop_front();
                chk("b_cnt_flat", cnt_b, e.cnt);
                chk("b_total", 80'(tot_b), 80'(e.tot));
                chk("b_overflow", 80'(ovf_b), 80'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (vld_c && rdy_c) begin
            if (qc.size() == 0) unexpected("c_out");
            else begin
                e = qc.pop_front();
                chk("c_cnt_flat", 80'(cnt_c), e.cnt);
                chk("c_total", 80'(tot_c), 80'(e.tot));
                chk("c_overflow", 80'(ovf_c), 80'(e.ovf));
            end
        end
    end

    // start, then XOR mask into sig_a after the ARM edge and every COUNT edge
    task automatic run_a(input logic [4:0] mask, output int edges);
        sig_a   = '0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        edges   = 1;
        while (!vld_a && edges < 40) begin
            tick();
            edges++;
            sig_a ^= mask;
        end
    endtask

    function automatic logic [4:0] fa(input logic [2:0] v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c, c, b, a};
    endfunction

    logic [2:0] vec [8] = '{3'b010, 3'b011, 3'b010, 3'b111, 3'b000, 3'b111, 3'b101, 3'b100};

    initial begin
        exp_t e;
        int   edges;
        logic seen;

        rst_n = 1'b0;
        {start_a, clear_a, start_b, clear_b, start_c, clear_c} = '0;
        {sig_a, sig_b, sig_c} = '0;
        {rdy_a, rdy_b, rdy_c} = 3'b111;
        repeat (2) tick();
        chk("rst_valid", 80'(vld_a), 80'(0));
        chk("rst_busy", 80'(busy_a), 80'(0));
        chk("rst_cnt", cnt_a, 80'(0));
        chk("rst_total", 80'(tot_a), 80'(0));
        chk("rst_ovf", 80'(ovf_a), 80'(0));
        rst_n = 1'b1;
        tick();

        // single net toggling every cycle
        e.cnt = '0; e.cnt[15:0] = 16'd8; e.tot = 19'd8; e.ovf = 1'b0;
        qa.push_back(e);
        run_a(5'b00001, edges);
        chk("a_latency", 80'(edges), 80'(10));
        tick();
        chk("a_valid_drop", 80'(vld_a), 80'(0));

        // consumer stalls in HOLD; start pulse during HOLD must be ignored
        e.cnt = {16'd8, 16'd0, 16'd8, 16'd8, 16'd0}; e.tot = 19'd24; e.ovf = 1'b0;
        qa.push_back(e);
        rdy_a = 1'b0;
        run_a(5'b10110, edges);
        chk("a_latency2", 80'(edges), 80'(10));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start_a = (i == 5);
            tick();
            if (!vld_a) seen = 1'b1;
        end
        start_a = 1'b0;
        chk("hold_valid_dropped", 80'(seen), 80'(0));
        rdy_a = 1'b1;
        tick();
        chk("hold_release_valid", 80'(vld_a), 80'(0));
        chk("hold_release_busy", 80'(busy_a), 80'(0));
        tick();
        chk("start_not_queued", 80'(busy_a), 80'(0));

        // clear beats start in IDLE, then clear mid-COUNT
        clear_a = 1'b1; start_a = 1'b1;
        tick();
        clear_a = 1'b0; start_a = 1'b0;
        chk("clr_start_busy", 80'(busy_a), 80'(0));
        chk("clr_start_cnt", cnt_a, 80'(0));
        chk("clr_start_total", 80'(tot_a), 80'(0));
        sig_a = '0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) begin
            tick();
            sig_a ^= 5'b00011;
        end
        chk("pre_clear_busy", 80'(busy_a), 80'(1));
        chk("pre_clear_total", 80'(tot_a), 80'(6));
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        chk("clr_busy", 80'(busy_a), 80'(0));
        chk("clr_valid", 80'(vld_a), 80'(0));
        chk("clr_cnt", cnt_a, 80'(0));
        chk("clr_total", 80'(tot_a), 80'(0));
        chk("clr_ovf", 80'(ovf_a), 80'(0));
        seen = 1'b0;
        repeat (14) begin
            tick();
            if (vld_a) seen = 1'b1;
        end
        chk("clr_no_valid", 80'(seen), 80'(0));

        // full-adder nets {carry,sum,c,b,a}; toggles a=3 b=3 c=6 sum=6 carry=6
        e.cnt = {16'd6, 16'd6, 16'd6, 16'd3, 16'd3}; e.tot = 19'd24; e.ovf = 1'b0;
        qb.push_back(e);
        sig_b = fa(vec[0]); start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        for (int k = 1; k < 8; k++) begin
            if (k == 7) chk("b_not_early", 80'(vld_b), 80'(0));
            sig_b = fa(vec[k]);
            tick();
        end
        chk("b_valid", 80'(vld_b), 80'(1));
        tick();

        // async reset while COUNT has cyc=10
        sig_c = '0; start_c = 1'b1;
        tick();
        start_c = 1'b0;
        repeat (11) begin
            tick();
            sig_c ^= 5'b00001;
        end
        chk("pre_rst_ovf", 80'(ovf_c), 80'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 80'(busy_c), 80'(0));
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 80'(vld_c), 80'(0));
        chk("mid_rst_cnt", 80'(cnt_c), 80'(0));
        chk("mid_rst_total", 80'(tot_c), 80'(0));
        chk("mid_rst_ovf", 80'(ovf_c), 80'(0));
        tick();

        // 12 toggles into a 3-bit counter
        e.cnt = '0;
`ifdef ACT_SAT_EN
        e.cnt[2:0] = 3'd7;
`else
        e.cnt[2:0] = 3'd4;
`endif
        e.tot = 19'd12; e.ovf = 1'b1;
        qc.push_back(e);
        sig_c = '0; start_c = 1'b1;
        tick();
        start_c = 1'b0;
        edges = 1;
        while (!vld_c && edges < 40) begin
            tick();
            edges++;
            sig_c ^= 5'b00001;
        end
        chk("c_latency", 80'(edges), 80'(14));

        repeat (3) tick();
        chk("scoreboard_empty", 80'(qa.size() + qb.size() + qc.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
